jtag_tap: RTL and testbench
===========================

Name: jtag_tap

Overview:
- JTAG target (TAP controller) that answers a JTAG master: receives tck/tms/tdi, drives tdo.
- Oversamples the JTAG pins in the system clk domain and implements the full 16-state IEEE 1149.1 TAP FSM.
- Provides an instruction register (IR), a BYPASS register, an IDCODE register and a USER data register.
- The USER register exchanges bytes with a receive FIFO (write side) and a transmit FIFO (read side). Used on-chip as a loopback target for the master and as a debug endpoint.

Parameters:
- DATA_INSTRUCTION, 6, IR width in bits.
- DATA_FIFO, 8, USER data register width and FIFO word width.
- IDCODE_VALUE, 32'h1234_5677, 32-bit IDCODE; bit 0 must be 1.
- INSTR_IDCODE, 6'h06, IR code selecting IDCODE.
- INSTR_USER, 6'h08, IR code selecting USER.

Ports:
- clk  in  1  system clock; must run at least 4x tck.
- rst  in  1  synchronous, active-high reset.
- tck  in  1  JTAG clock from the master, asynchronous to clk.
- tms  in  1  JTAG mode select.
- tdi  in  1  JTAG serial data in.
- tdo  out  1  JTAG serial data out.
- wdata_data  out  DATA_FIFO  word to the receive FIFO.
- wr_data  out  1  receive FIFO write strobe, 1 clk wide.
- full_data  in  1  receive FIFO full.
- rdata_data  in  DATA_FIFO  head word of the transmit FIFO (show-ahead).
- rd_data  out  1  transmit FIFO read strobe, 1 clk wide.
- empty_data  in  1  transmit FIFO empty.
- ir_value  out  DATA_INSTRUCTION  current (updated) instruction.
- tap_state  out  4  current TAP state encoding.
- overflow  out  1  sticky: a USER update was dropped because the receive FIFO was full.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Input synchronisation:
  - 2-flop synchronisers on tck, tms and tdi, then a third tck flop for edge detection.
  - rise = sync tck 0->1; fall = sync tck 1->0.
  - FSM, shift registers and FIFO strobes act only in the clk cycle where rise=1.
  - tdo updates only in the cycle where fall=1.
- Reset values: TAP state = TEST_LOGIC_RESET, ir_value = INSTR_IDCODE, tdo = 0, wr_data = 0, rd_data = 0, overflow = 0, all shift registers = 0.
- TAP FSM: standard 1149.1 transitions on tms at rise, 16 states encoded per 1149.1 (TLR = 4'hF, RTI = 4'hC, …).
  - Five consecutive rises with tms=1 reach TLR from any state.
  - Entering TLR forces ir_value to INSTR_IDCODE.
- IR:
  - Capture-IR loads {0…, 2'b01}.
  - Shift-IR shifts right: tdi enters the MSB, the LSB drives tdo.
  - Update-IR copies the shift register to ir_value.
- DR select:
  - ir_value == INSTR_IDCODE selects the 32-bit IDCODE register.
  - ir_value == INSTR_USER selects the DATA_FIFO-bit USER register.
  - Any other code selects the 1-bit BYPASS register; all-ones is BYPASS by definition.
- Capture-DR:
  - IDCODE: loads IDCODE_VALUE.
  - BYPASS: loads 0.
  - USER, empty_data=0: loads rdata_data and pulses rd_data for exactly 1 clk in the same cycle.
  - USER, empty_data=1: loads 0; no rd_data pulse.
- Shift-DR: LSB first, same direction as IR.
- Update-DR with USER selected:
  - full_data=0: wdata_data = shift register and wr_data pulses for 1 clk.
  - full_data=1: no write; overflow set and held until rst.
- tdo:
  - At fall, in Shift-IR/Shift-DR: tdo = LSB of the active shift register.
  - At fall, in any other state: tdo = 0.
- Latency: tck pin edge to state change is 3–4 clk; tdo changes 3–4 clk after a falling pin edge.
- Boundary conditions:
  - Exit/Pause states hold the shift contents unchanged.
  - Capture with no Shift, then Update, writes the captured value.
  - rst during Shift aborts the scan; any partial data is discarded.
  - tck stopped: state and registers hold.
  - Glitches shorter than 2 clk may be lost; this is not required to be handled.

Decomposition:
- Package jtag_pkg holds:
  - tap_state_t enum with the 16 states and their 1149.1 encodings.
  - INSTR_BYPASS constant.
  - A next-state function shared with the existing master.
- Sub-module jtag_sync: 3-flop synchroniser plus edge detector for tck, registered tms/tdi, outputs rise/fall. Everything else stays in jtag_tap.

Test Plan:
- Reset, then 5 tck with tms=1 -> tap_state = 4'hF, ir_value = 6'h06, tdo = 0, overflow = 0.
- From RTI, scan DR with 32 Shift-DR cycles -> tdo bits read LSB first = 32'h1234_5677.
- Shift-IR with 6'h3F, then 8 DR shift bits of 8'hA5 plus 1 lead bit -> tdo returns 0 followed by tdi delayed 1 tck.
- IR = 6'h08; transmit FIFO head = 8'h3C, empty_data = 0; scan DR with tdi = 8'hC3:
  - rd_data pulses once at Capture-DR.
  - tdo shifts out 8'h3C.
  - At Update-DR, wdata_data = 8'hC3 with one wr_data pulse.
- Same USER scan with full_data = 1 -> no wr_data, overflow = 1; a subsequent scan with empty_data = 1 shifts out 8'h00 with no rd_data.
- Assert rst mid Shift-DR after 3 bits -> next clk tap_state = 4'hF, no wr_data, ir_value = 6'h06.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encodings, fixed instruction codes and
// the TAP next-state function (also used by the JTAG master).
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0, EXIT1_DR   = 4'h1, SHIFT_DR  = 4'h2, PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4, UPDATE_DR  = 4'h5, CAPTURE_DR = 4'h6, SELECT_DR = 4'h7,
    EXIT2_IR   = 4'h8, EXIT1_IR   = 4'h9, SHIFT_IR  = 4'hA, PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC, UPDATE_IR  = 4'hD, CAPTURE_IR = 4'hE, TEST_RESET = 4'hF
  } tap_state_t;

  localparam logic [5:0] INSTR_BYPASS = 6'h3F;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TEST_RESET: tap_next = tms ? TEST_RESET : RUN_IDLE;
      RUN_IDLE:   tap_next = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  tap_next = tms ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: tap_next = tms ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   tap_next = tms ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   tap_next = tms ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   tap_next = tms ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   tap_next = tms ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  tap_next = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:  tap_next = tms ? TEST_RESET : CAPTURE_IR;
      CAPTURE_IR: tap_next = tms ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   tap_next = tms ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   tap_next = tms ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   tap_next = tms ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   tap_next = tms ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  tap_next = tms ? SELECT_DR  : RUN_IDLE;
      default:    tap_next = TEST_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// FIFO-side bundle of the TAP USER register: receive FIFO write port and
// show-ahead transmit FIFO read port.
interface jtag_tap_if #(parameter int DATA_FIFO = 8);
  logic [DATA_FIFO-1:0] wdata_data;
  logic                 wr_data;
  logic                 full_data;
  logic [DATA_FIFO-1:0] rdata_data;
  logic                 rd_data;
  logic                 empty_data;

  modport master (output wdata_data, wr_data, rd_data,
                  input  full_data, rdata_data, empty_data);
  modport slave  (input  wdata_data, wr_data, rd_data,
                  output full_data, rdata_data, empty_data);
endinterface

// File: rtl/jtag_sync.sv
// Brings tck/tms/tdi into the clk domain; rise/fall are single-cycle strobes
// of the synchronised tck, with tms/tdi aligned to them.
module jtag_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic rise_o,
  output logic fall_o,
  output logic tms_o,
  output logic tdi_o
);
  logic [2:0] tck_q;
  logic [1:0] tms_q, tdi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], tck_i};
      tms_q <= {tms_q[0], tms_i};
      tdi_q <= {tdi_q[0], tdi_i};
    end
  end

  assign rise_o = tck_q[1] & ~tck_q[2];
  assign fall_o = ~tck_q[1] & tck_q[2];
  assign tms_o  = tms_q[1];
  assign tdi_o  = tdi_q[1];
endmodule

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP target clocked entirely by clk: IR, BYPASS, IDCODE and a
// USER register that pops the transmit FIFO at Capture and pushes the receive FIFO at Update.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int                          DATA_INSTRUCTION = 6,
  parameter int                          DATA_FIFO        = 8,
  parameter logic [31:0]                 IDCODE_VALUE     = 32'h1234_5677,
  parameter logic [DATA_INSTRUCTION-1:0] INSTR_IDCODE     = 6'h06,
  parameter logic [DATA_INSTRUCTION-1:0] INSTR_USER       = 6'h08
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tck,
  input  logic                        tms,
  input  logic                        tdi,
  output logic                        tdo,
  jtag_tap_if.master                  fifo,
  output logic [DATA_INSTRUCTION-1:0] ir_value,
  output logic [3:0]                  tap_state,
  output logic                        overflow
);
  localparam logic [DATA_INSTRUCTION-1:0] IR_CAPTURE = {{(DATA_INSTRUCTION-2){1'b0}}, 2'b01};

  logic rise, fall, tms_s, tdi_s;

  jtag_sync u_sync (
    .clk(clk), .rst(rst), .tck_i(tck), .tms_i(tms), .tdi_i(tdi),
    .rise_o(rise), .fall_o(fall), .tms_o(tms_s), .tdi_o(tdi_s)
  );

  tap_state_t                  state_q, state_d;
  logic [DATA_INSTRUCTION-1:0] ir_q, ir_sr_q;
  logic [31:0]                 id_sr_q;
  logic [DATA_FIFO-1:0]        user_sr_q, wdata_q;
  logic                        bypass_q, tdo_q, wr_q, rd_q, ovf_q;
  logic                        sel_id, sel_user;

  assign state_d  = tap_next(state_q, tms_s);
  assign sel_id   = (ir_q == INSTR_IDCODE);
  assign sel_user = (ir_q == INSTR_USER) && !sel_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TEST_RESET;
      ir_q      <= INSTR_IDCODE;
      ir_sr_q   <= '0;
      id_sr_q   <= '0;
      user_sr_q <= '0;
      bypass_q  <= 1'b0;
      wdata_q   <= '0;
      tdo_q     <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      if (rise) begin
        state_q <= state_d;
        // Register actions belong to the state being left on this tck rise
        case (state_q)
          CAPTURE_IR: ir_sr_q <= IR_CAPTURE;
          SHIFT_IR:   ir_sr_q <= {tdi_s, ir_sr_q[DATA_INSTRUCTION-1:1]};
          UPDATE_IR:  ir_q    <= ir_sr_q;
          CAPTURE_DR: begin
            if (sel_id) id_sr_q <= IDCODE_VALUE;
            else if (sel_user) begin
              user_sr_q <= fifo.empty_data ? '0 : fifo.rdata_data;
              rd_q      <= !fifo.empty_data;
            end else bypass_q <= 1'b0;
          end
          SHIFT_DR: begin
            if (sel_id)        id_sr_q   <= {tdi_s, id_sr_q[31:1]};
            else if (sel_user) user_sr_q <= {tdi_s, user_sr_q[DATA_FIFO-1:1]};
            else               bypass_q  <= tdi_s;
          end
          UPDATE_DR: begin
            if (sel_user) begin
              if (!fifo.full_data) begin
                wdata_q <= user_sr_q;
                wr_q    <= 1'b1;
              end else ovf_q <= 1'b1;
            end
          end
          default: ;
        endcase
        if (state_d == TEST_RESET) ir_q <= INSTR_IDCODE;
      end
      if (fall) begin
        case (state_q)
          SHIFT_IR: tdo_q <= ir_sr_q[0];
          SHIFT_DR: tdo_q <= sel_id ? id_sr_q[0] : (sel_user ? user_sr_q[0] : bypass_q);
          default:  tdo_q <= 1'b0;
        endcase
      end
    end
  end

  assign tdo             = tdo_q;
  assign ir_value        = ir_q;
  assign tap_state       = state_q;
  assign overflow        = ovf_q;
  assign fifo.wdata_data = wdata_q;
  assign fifo.wr_data    = wr_q;
  assign fifo.rd_data    = rd_q;
endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: bit-bangs tck/tms/tdi, queues expected tdo words
// per scan and checks FIFO strobes, overflow and reset behaviour.
module tb_jtag_tap;
  logic       clk = 1'b0, rst = 1'b1;
  logic       tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic       tdo;
  logic [5:0] ir_value;
  logic [3:0] tap_state;
  logic       overflow;

  jtag_tap_if #(.DATA_FIFO(8)) fif ();

  jtag_tap dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .fifo(fif), .ir_value(ir_value), .tap_state(tap_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          wr_cnt = 0, rd_cnt = 0;
  logic [7:0]  last_wdata = '0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (fif.wr_data) begin wr_cnt++; last_wdata = fif.wdata_data; end
    if (fif.rd_data) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tck period; tdo is sampled just before the rise, like a master would
  task automatic tck_cyc(input logic m, input logic d, output logic t);
    tms = m; tdi = d;
    wait_clk(4);
    t = tdo;
    tck = 1'b1;
    wait_clk(6);
    tck = 1'b0;
    wait_clk(6);
  endtask

  task automatic tck_n(input logic m, input int n);
    logic t;
    for (int i = 0; i < n; i++) tck_cyc(m, 1'b0, t);
  endtask

  // RTI -> DR scan of n bits -> Update -> RTI
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic t;
    dout = '0;
    tck_n(1'b1, 1); tck_n(1'b0, 2);
    for (int i = 0; i < n; i++) begin
      tck_cyc(i == n - 1, din[i], t);
      dout[i] = t;
    end
    tck_n(1'b1, 1); tck_n(1'b0, 1);
  endtask

  task automatic scan_ir(input logic [5:0] din, output logic [31:0] dout);
    logic t;
    dout = '0;
    tck_n(1'b1, 2); tck_n(1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      tck_cyc(i == 5, din[i], t);
      dout[i] = t;
    end
    tck_n(1'b1, 1); tck_n(1'b0, 1);
  endtask

  initial begin
    logic [31:0] got;
    logic        t;
    int          wr0, rd0;
    fif.full_data = 1'b0; fif.empty_data = 1'b1; fif.rdata_data = 8'h00;

    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check("rst_state", tap_state, 4'hF);
    check("rst_ir", ir_value, 6'h06);
    check("rst_tdo", tdo, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_wr", fif.wr_data, 1'b0);

    tck_n(1'b1, 5);
    check("tlr_state", tap_state, 4'hF);
    check("tlr_ir", ir_value, 6'h06);
    tck_n(1'b0, 1);
    check("rti_state", tap_state, 4'hC);

    // IDCODE read
    exp_q.push_back(32'h1234_5677);
    scan_dr(32'h0, 32, got);
    check("idcode", got, exp_q.pop_front());
    check("rti_after_dr", tap_state, 4'hC);

    // BYPASS: capture value for IR first, then 1-tck delay through DR
    exp_q.push_back(32'h01);
    scan_ir(6'h3F, got);
    check("ir_capture", got, exp_q.pop_front());
    check("ir_bypass", ir_value, 6'h3F);
    exp_q.push_back(32'h14A);
    scan_dr(32'h0A5, 9, got);
    check("bypass", got, exp_q.pop_front());

    // USER loopback
    scan_ir(6'h08, got);
    check("ir_user", ir_value, 6'h08);
    fif.rdata_data = 8'h3C; fif.empty_data = 1'b0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    exp_q.push_back(32'h3C);
    scan_dr(32'hC3, 8, got);
    wait_clk(4);
    check("user_tdo", got, exp_q.pop_front());
    check("user_rd", rd_cnt - rd0, 1);
    check("user_wr", wr_cnt - wr0, 1);
    check("user_wdata", last_wdata, 8'hC3);
    check("user_ovf0", overflow, 1'b0);

    // receive FIFO full: dropped update sets overflow
    fif.full_data = 1'b1;
    wr0 = wr_cnt; rd0 = rd_cnt;
    exp_q.push_back(32'h3C);
    scan_dr(32'hC3, 8, got);
    wait_clk(4);
    check("full_tdo", got, exp_q.pop_front());
    check("full_wr", wr_cnt - wr0, 0);
    check("full_rd", rd_cnt - rd0, 1);
    check("full_ovf", overflow, 1'b1);

    // transmit FIFO empty: zeros out, no pop
    fif.full_data = 1'b0; fif.empty_data = 1'b1;
    wr0 = wr_cnt; rd0 = rd_cnt;
    exp_q.push_back(32'h00);
    scan_dr(32'h5A, 8, got);
    wait_clk(4);
    check("empty_tdo", got, exp_q.pop_front());
    check("empty_rd", rd_cnt - rd0, 0);
    check("empty_wdata", last_wdata, 8'h5A);
    check("ovf_sticky", overflow, 1'b1);

    // Capture then Update with no Shift writes the captured word
    fif.empty_data = 1'b0; fif.rdata_data = 8'h96;
    wr0 = wr_cnt;
    tck_n(1'b1, 1); tck_n(1'b0, 1); tck_n(1'b1, 2); tck_n(1'b0, 1);
    wait_clk(4);
    check("noshift_wr", wr_cnt - wr0, 1);
    check("noshift_wdata", last_wdata, 8'h96);
    check("noshift_state", tap_state, 4'hC);

    // reset in the middle of a USER Shift-DR
    wr0 = wr_cnt;
    tck_n(1'b1, 1); tck_n(1'b0, 2);
    for (int i = 0; i < 3; i++) tck_cyc(1'b0, 1'b1, t);
    check("pre_rst_state", tap_state, 4'h2);
    rst = 1'b1;
    wait_clk(1);
    check("midrst_state", tap_state, 4'hF);
    check("midrst_ir", ir_value, 6'h06);
    check("midrst_ovf", overflow, 1'b0);
    rst = 1'b0;
    wait_clk(20);
    check("midrst_wr", wr_cnt - wr0, 0);
    check("hold_state", tap_state, 4'hF);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
